// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keyboard and joystick inputs into per-player arcade controls,
// with rotation, autofire on button 0 and stretched coin pulses.
//
// state        | meaning
// IDLE         | waiting for a rising edge on the coin source
// PULSE        | coin output high, counting down COIN_CYCLES
// WAIT_RELEASE | pulse done, source still held; wait for release
module arcade_input_mapper #(
    parameter int NUM_PLAYERS   = 2,
    parameter int NUM_BUTTONS   = 1,
    parameter int COIN_CYCLES   = 1200000,
    parameter int AUTOFIRE_DIV  = 600000,
    parameter int COIN_ON_START = 1
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [10:0]            ps2_key,
    input  logic [15:0]            joystick_0,
    input  logic [15:0]            joystick_1,
    input  logic [1:0]             rotate,
    input  logic                   autofire_en,
    output logic [3:0]             p1_dir,
    output logic [3:0]             p2_dir,
    output logic [NUM_BUTTONS-1:0] p1_btn,
    output logic [NUM_BUTTONS-1:0] p2_btn,
    output logic [1:0]             start,
    output logic [1:0]             coin
);

    localparam int CW = (COIN_CYCLES  > 1) ? $clog2(COIN_CYCLES + 1)  : 1;
    localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV + 1) : 1;
    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES - 1);
    localparam logic [AW-1:0] AF_LOAD   = AW'(AUTOFIRE_DIV - 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PULSE        = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;

    localparam bit MERGE = (NUM_PLAYERS == 1);

    // kb_q / key_hit layout: [3:0] {up,down,left,right}, [7:4] btn0..3,
    // [9:8] start1/2, [11:10] coin1/2
    logic        tog_q;
    logic [11:0] kb_q;
    logic [11:0] key_hit;
    logic        key_event;
    logic        key_ext;

    assign key_event = ps2_key[10] != tog_q;
    assign key_ext   = ps2_key[8];

    always_comb begin
        key_hit = '0;
        case (ps2_key[7:0])
            8'h75:        key_hit[3]  = 1'b1;
            8'h72:        key_hit[2]  = 1'b1;
            8'h6B:        key_hit[1]  = 1'b1;
            8'h74:        key_hit[0]  = 1'b1;
            8'h29, 8'h14: key_hit[4]  = 1'b1;
            8'h11:        key_hit[5]  = 1'b1;
            8'h12:        key_hit[6]  = !key_ext;
            8'h1A:        key_hit[7]  = !key_ext;
            8'h05:        key_hit[8]  = !key_ext;
            8'h06:        key_hit[9]  = !key_ext;
            8'h2E:        key_hit[10] = !key_ext;
            8'h36:        key_hit[11] = !key_ext;
            default:      ;
        endcase
        for (int k = 0; k < 4; k++) begin
            if (k >= NUM_BUTTONS) key_hit[4+k] = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        tog_q <= ps2_key[10];
        if (reset) begin
            kb_q <= '0;
        end else if (key_event) begin
            for (int i = 0; i < 12; i++) begin
                if (key_hit[i]) kb_q[i] <= ps2_key[9];
            end
        end
    end

    logic [3:0]             j0_dir, j1_dir, raw1_dir, raw2_dir;
    logic [NUM_BUTTONS-1:0] j0_btn, j1_btn, raw1_btn, raw2_btn, af_mask;
    logic                   j0_start, j1_start, j0_coin, j1_coin;
    logic [1:0]             start_src, coin_src;

    assign j0_dir   = joystick_0[3:0];
    assign j1_dir   = joystick_1[3:0];
    assign j0_btn   = joystick_0[4 +: NUM_BUTTONS];
    assign j1_btn   = joystick_1[4 +: NUM_BUTTONS];
    assign j0_start = joystick_0[4+NUM_BUTTONS];
    assign j1_start = joystick_1[4+NUM_BUTTONS];
    assign j0_coin  = joystick_0[5+NUM_BUTTONS];
    assign j1_coin  = joystick_1[5+NUM_BUTTONS];

    always_comb begin
        raw1_dir = kb_q[3:0] | j0_dir | (MERGE ? j1_dir : 4'b0);
        raw2_dir = MERGE ? 4'b0 : j1_dir;
        raw1_btn = kb_q[4 +: NUM_BUTTONS] | j0_btn | (MERGE ? j1_btn : '0);
        raw2_btn = MERGE ? '0 : j1_btn;
        start_src[0] = kb_q[8] | j0_start | (MERGE & j1_start);
        start_src[1] = kb_q[9] | (!MERGE & j1_start);
        coin_src[0]  = kb_q[10] | j0_coin | (MERGE & j1_coin)
                     | ((COIN_ON_START != 0) & start_src[0]);
        coin_src[1]  = kb_q[11] | (!MERGE & j1_coin)
                     | ((COIN_ON_START != 0) & start_src[1]);
    end

    // Bits of the joystick words and key latches this configuration never reads.
    logic unused_bits;
    assign unused_bits = ^{joystick_0, joystick_1, kb_q};

    function automatic logic [3:0] rot_dir(input logic [3:0] r, input logic [1:0] sel);
        case (sel)
            2'd1:    rot_dir = {r[1], r[0], r[2], r[3]};
            2'd2:    rot_dir = {r[2], r[3], r[0], r[1]};
            2'd3:    rot_dir = {r[0], r[1], r[3], r[2]};
            default: rot_dir = r;
        endcase
    endfunction

    logic [AW-1:0] af_cnt;
    logic          af_phase;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (af_cnt == '0) begin
            af_cnt   <= AF_LOAD;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt - 1'b1;
        end
    end

    always_comb begin
        af_mask    = '1;
        af_mask[0] = !autofire_en || af_phase;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            p1_dir <= '0;
            p2_dir <= '0;
            p1_btn <= '0;
            p2_btn <= '0;
            start  <= '0;
        end else begin
            p1_dir <= rot_dir(raw1_dir, rotate);
            p2_dir <= rot_dir(raw2_dir, rotate);
            p1_btn <= raw1_btn & af_mask;
            p2_btn <= raw2_btn & af_mask;
            start  <= start_src;
        end
    end

    logic [1:0]    src_q, src_d;
    logic [1:0]    coin_st  [2];
    logic [CW-1:0] coin_cnt [2];

    // Source history resets high so a source held through reset reads as
    // already pressed and must be released before it can coin again.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            src_q <= '1;
            src_d <= '1;
            coin  <= '0;
            for (int n = 0; n < 2; n++) begin
                coin_st[n]  <= IDLE;
                coin_cnt[n] <= '0;
            end
        end else begin
            src_q <= coin_src;
            src_d <= src_q;
            for (int n = 0; n < 2; n++) begin
                case (coin_st[n])
                    IDLE: begin
                        if (src_q[n] && !src_d[n]) begin
                            coin_st[n]  <= PULSE;
                            coin[n]     <= 1'b1;
                            coin_cnt[n] <= COIN_LOAD;
                        end
                    end
                    PULSE: begin
                        if (coin_cnt[n] == '0) begin
                            coin[n]    <= 1'b0;
                            coin_st[n] <= src_q[n] ? WAIT_RELEASE : IDLE;
                        end else begin
                            coin_cnt[n] <= coin_cnt[n] - 1'b1;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (!src_q[n]) coin_st[n] <= IDLE;
                    end
                    default: begin
                        coin_st[n] <= IDLE;
                        coin[n]    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
